// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the UART transmitter and the arbiter.
//   master : environment side (requesters + UART), drives req/req_data/err_clear/uart_tx_done
//   slave  : arbiter side, drives acks, UART launch signals and status
// Signals:
//   req[N_REQ]          per-requester byte valid
//   req_data[8*N_REQ]   requester i byte at [8i+7:8i]
//   req_ack[N_REQ]      one-cycle capture pulse
//   err_clear           clears the sticky timeout flag
//   uart_tx_data[8]     byte presented to the UART
//   uart_tx_ready       one-cycle UART start strobe
//   uart_tx_done        one-cycle UART completion pulse
//   busy                arbiter not idle
//   grant_id[clog2]     last granted requester
//   timeout_err         sticky watchdog abort flag
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ack;
    logic               err_clear;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_ready;
    logic               uart_tx_done;
    logic               busy;
    logic [ID_W-1:0]    grant_id;
    logic               timeout_err;

    modport master (
        output req, req_data, err_clear, uart_tx_done,
        input  req_ack, uart_tx_data, uart_tx_ready, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, req_data, err_clear, uart_tx_done,
        output req_ack, uart_tx_data, uart_tx_ready, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte producers. Round-robin grant,
// byte capture with a one-cycle ack and start strobe, wait for UART completion
// under a watchdog, then a fixed idle gap before the next grant.
// Ports:
//   clock  system clock
//   reset  asynchronous active-high reset
//   bus    uart_tx_arbiter_if.slave (see interface file for signal list)
// Parameters:
//   N_REQ          requesters, 2..8
//   TIMEOUT_CYCLES WAIT_DONE watchdog limit, 0 disables
//   GAP_CYCLES     idle clocks after each byte, >= 1
// Build option:
//   UART_ARB_FIXED_PRIORITY_EN  lowest-index requester always wins (no rr pointer)
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned GAP_CYCLES     = 1
) (
    input logic            clock,
    input logic            reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned ID_W     = $clog2(N_REQ);
    localparam int unsigned CNT_MAX  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] req_ack;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             busy;
    logic [ID_W-1:0]  grant_id;
    logic             timeout_err;

    logic             win_valid;
    logic [ID_W-1:0]  win_id;

`ifdef UART_ARB_FIXED_PRIORITY_EN
    // Lowest-index requester wins; scan high to low so the last hit is the lowest.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[ID_W'(i)]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end
`else
    localparam int unsigned SUM_W = ID_W + 1;

    logic [ID_W-1:0] ptr;

    // Round-robin: first set bit at ptr+1 .. ptr+N_REQ, modulo N_REQ.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [ID_W-1:0]  idx;
        win_valid = 1'b0;
        win_id    = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!win_valid && bus.req[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end
`endif

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ack     <= '0;
            tx_data     <= '0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
            ptr         <= ID_W'(N_REQ - 1);
`endif
        end else begin
            req_ack  <= '0;
            tx_ready <= 1'b0;
            // A watchdog set later in this block overrides the clear.
            if (bus.err_clear) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        tx_data  <= bus.req_data[{win_id, 3'b000} +: 8];
                        req_ack  <= N_REQ'(1) << win_id;
                        tx_ready <= 1'b1;
                        grant_id <= win_id;
`ifndef UART_ARB_FIXED_PRIORITY_EN
                        ptr      <= win_id;
`endif
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.uart_tx_done) begin
                        cnt   <= '0;
                        state <= GAP;
                    end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TO_LAST)) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= GAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cnt == CNT_W'(GAP_LAST)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack       = req_ack;
    assign bus.uart_tx_data  = tx_data;
    assign bus.uart_tx_ready = tx_ready;
    assign bus.busy          = busy;
    assign bus.grant_id      = grant_id;
    assign bus.timeout_err   = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset values, single byte launch, stray
// completion pulses, watchdog timeout with err_clear, async reset mid-transfer,
// round-robin ordering and wrap-around.
module tb_uart_tx_arbiter;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    uart_tx_arbiter_if #(.N_REQ(4)) bus ();

    uart_tx_arbiter #(
        .N_REQ         (4),
        .TIMEOUT_CYCLES(50),
        .GAP_CYCLES    (1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the launch of requester id, checks it, then models a UART
    // that reports done 10 cycles after the strobe.
    task automatic serve(input int id, input logic [7:0] d, input logic [3:0] next_req);
        int k;
        k = 0;
        while (bus.uart_tx_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("rr_launch_seen", 32'(k < 20), 32'd1);
        check("rr_ack",   32'(bus.req_ack), 32'(4'b0001 << id));
        check("rr_data",  32'(bus.uart_tx_data), 32'(d));
        check("rr_grant", 32'(bus.grant_id), 32'(id));
        bus.req = next_req;
        tick();
        check("rr_ack_one_cycle",   32'(bus.req_ack), 32'd0);
        check("rr_ready_one_cycle", 32'(bus.uart_tx_ready), 32'd0);
        repeat (8) tick();
        bus.uart_tx_done = 1'b1;
        tick();
        bus.uart_tx_done = 1'b0;
        check("rr_busy_gap", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.req          = '0;
        bus.req_data     = '0;
        bus.err_clear    = 1'b0;
        bus.uart_tx_done = 1'b0;

        // Reset values
        #3;
        check("rst_ack",   32'(bus.req_ack), 32'd0);
        check("rst_ready", 32'(bus.uart_tx_ready), 32'd0);
        check("rst_data",  32'(bus.uart_tx_data), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
        check("rst_terr",  32'(bus.timeout_err), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single byte from requester 0
        bus.req_data = 32'h0000_0041;
        bus.req      = 4'b0001;
        tick();
        check("t1_ack",   32'(bus.req_ack), 32'h1);
        check("t1_ready", 32'(bus.uart_tx_ready), 32'd1);
        check("t1_data",  32'(bus.uart_tx_data), 32'h41);
        check("t1_busy",  32'(bus.busy), 32'd1);
        check("t1_grant", 32'(bus.grant_id), 32'd0);
        bus.req = '0;
        tick();
        check("t1_ack_low",   32'(bus.req_ack), 32'd0);
        check("t1_ready_low", 32'(bus.uart_tx_ready), 32'd0);
        check("t1_data_hold", 32'(bus.uart_tx_data), 32'h41);
        repeat (18) tick();
        check("t1_busy_wait", 32'(bus.busy), 32'd1);
        bus.uart_tx_done = 1'b1;
        tick();
        check("t1_busy_gap", 32'(bus.busy), 32'd1);
        // done held into GAP is a stray pulse
        tick();
        bus.uart_tx_done = 1'b0;
        check("t1_busy_idle",  32'(bus.busy), 32'd0);
        check("gap_stray_ack", 32'(bus.req_ack), 32'd0);
        check("gap_stray_rdy", 32'(bus.uart_tx_ready), 32'd0);

        // Stray done in IDLE
        bus.uart_tx_done = 1'b1;
        tick();
        bus.uart_tx_done = 1'b0;
        check("idle_stray_busy", 32'(bus.busy), 32'd0);
        check("idle_stray_ack",  32'(bus.req_ack), 32'd0);
        tick();
        check("idle_stray_rdy",  32'(bus.uart_tx_ready), 32'd0);

        // Watchdog: no done, timeout after 50 clocks in WAIT_DONE
        bus.req_data = 32'h0000_5500;
        bus.req      = 4'b0010;
        tick();
        check("to_ack",   32'(bus.req_ack), 32'h2);
        check("to_grant", 32'(bus.grant_id), 32'd1);
        check("to_data",  32'(bus.uart_tx_data), 32'h55);
        bus.req = '0;
        repeat (49) tick();
        check("to_not_yet", 32'(bus.timeout_err), 32'd0);
        check("to_busy49",  32'(bus.busy), 32'd1);
        bus.err_clear = 1'b1;
        tick();
        check("to_set_wins", 32'(bus.timeout_err), 32'd1);
        check("to_busy_gap", 32'(bus.busy), 32'd1);
        tick();
        bus.err_clear = 1'b0;
        check("to_cleared", 32'(bus.timeout_err), 32'd0);
        check("to_idle",    32'(bus.busy), 32'd0);

        // Async reset in the first WAIT_DONE cycle
        bus.req_data = 32'h0077_0000;
        bus.req      = 4'b0100;
        tick();
        check("ar_ack",   32'(bus.req_ack), 32'h4);
        check("ar_ready", 32'(bus.uart_tx_ready), 32'd1);
        check("ar_grant", 32'(bus.grant_id), 32'd2);
        bus.req = '0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_ready0", 32'(bus.uart_tx_ready), 32'd0);
        check("ar_ack0",   32'(bus.req_ack), 32'd0);
        check("ar_busy0",  32'(bus.busy), 32'd0);
        check("ar_grant0", 32'(bus.grant_id), 32'd0);
        check("ar_data0",  32'(bus.uart_tx_data), 32'd0);
        tick();
        reset = 1'b0;

        // Round-robin with all requesters held; requester 0 first after reset
        bus.req_data = 32'h1312_1110;
        bus.req      = 4'b1111;
        serve(0, 8'h10, 4'b1111);
        serve(1, 8'h11, 4'b1111);
        serve(2, 8'h12, 4'b1111);
        serve(3, 8'h13, 4'b1111);
        serve(0, 8'h10, 4'b1111);
        serve(1, 8'h11, 4'b1111);
        // After requester 2, only 0 and 2 pending: wrap to 0, then 2, then 0
        serve(2, 8'h12, 4'b0101);
        serve(0, 8'h10, 4'b0101);
        serve(2, 8'h12, 4'b0101);
        serve(0, 8'h10, 4'b0000);
        tick();
        tick();
        check("end_idle", 32'(bus.busy), 32'd0);
        check("end_terr", 32'(bus.timeout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N_REQ byte-producing requesters.
- Runs a round-robin grant, latches the winner's byte, pulses the UART start strobe, then holds until the UART reports completion.
- Bounds each transfer with a watchdog timeout.
- Sits between application logic (button handlers, status reporters) and the UART instance in the top level.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 65535: max clocks in WAIT_DONE before abort; 0 disables the watchdog.
- GAP_CYCLES, 1: idle clocks inserted after each byte before the next grant; minimum 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester byte-valid; held high with data stable until acked.
- req_data  in  8*N_REQ  requester i's byte at bits [8i+7:8i].
- req_ack  out  N_REQ  one-cycle pulse; byte of requester i captured.
- err_clear  in  1  clears timeout_err.
- uart_tx_data  out  8  byte to the UART; stable from launch until the next launch.
- uart_tx_ready  out  1  one-cycle start strobe to the UART.
- uart_tx_done  in  1  one-cycle pulse from the UART when the stop bit completes.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(N_REQ)  index of the last granted requester.
- timeout_err  out  1  sticky flag; a transfer was aborted by the watchdog.

Behaviour:
- Reset values: state=IDLE, req_ack=0, uart_tx_ready=0, uart_tx_data=0, busy=0, grant_id=0, timeout_err=0, rr pointer=N_REQ-1 (requester 0 has first priority), counters=0.
- All outputs are registered.
- Asserting reset mid-transfer forces reset values immediately (async). Any byte in flight is abandoned and not re-sent.

State IDLE:
- If req is nonzero, select the winner w as the first set bit searching ptr+1, ptr+2, ..., ptr+N_REQ (mod N_REQ).
- On the next edge: uart_tx_data<=req_data[w], req_ack[w]<=1, uart_tx_ready<=1, grant_id<=w, ptr<=w, state<=WAIT_DONE.
- Latency: req sampled high at edge k gives ack and strobe high during cycle k+1.

State WAIT_DONE:
- req_ack and uart_tx_ready return to 0 after exactly one cycle.
- Watchdog counts clocks in this state.
- uart_tx_done=1 -> state<=GAP, counter cleared.
- If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES without done: timeout_err<=1, state<=GAP.
- uart_tx_done arriving in the first WAIT_DONE cycle (strobe still high) is accepted.

State GAP:
- Waits GAP_CYCLES clocks, then state<=IDLE.
- req is ignored in this state.

Handshake and boundary rules:
- uart_tx_done outside WAIT_DONE is ignored.
- A requester that drops req before its ack is not serviced; no partial capture.
- After an ack, a requester may present its next byte in the following cycle. It is granted again only after the other pending requesters (round-robin fairness).
- Single active requester: back-to-back bytes, one grant per 2+GAP_CYCLES+UART time.
- err_clear and a timeout on the same edge: the set wins.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIORITY_EN.
- Defined: the winner is always the lowest-index requester with req set. The rr pointer is unused; grant_id still updates.
- Undefined: round-robin as above.

Test Plan:
- Reset, req=4'b0001, req_data[7:0]=8'h41 -> next cycle req_ack=0001, uart_tx_ready=1 for one cycle, uart_tx_data=8'h41, busy=1; done pulse 20 cycles later -> busy=0 after GAP.
- req=4'b1111 held, data 8'h10/8'h11/8'h12/8'h13, model UART done after 10 cycles -> bytes sent in order 10,11,12,13,10...; each ack exactly one cycle.
- After requester 2 is granted, req=4'b0101 -> requester 0 granted next (wrap-around). With UART_ARB_FIXED_PRIORITY_EN, req 0 always wins while held.
- TIMEOUT_CYCLES=50, no uart_tx_done -> timeout_err=1 at 50 cycles in WAIT_DONE, return to IDLE; err_clear pulse -> timeout_err=0.
- Assert reset during WAIT_DONE -> uart_tx_ready=0, busy=0, req_ack=0 without a clock edge; after release, requester 0 has priority.
- Stray uart_tx_done pulses in IDLE and GAP -> no state change, no ack.
